// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S capture path: default word width, receiver
// states and word-select polarity.
package i2s_pkg;

  localparam int SAMPLE_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for one asynchronous input. With RISE set, q is a
// one-cycle pulse on the synchronised rising edge instead of the level.
module bit_sync #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0,
  parameter bit   RISE    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stage <= {DEPTH{RST_VAL}};
    else     stage <= {stage[DEPTH-2:0], d};
  end

  generate
    if (RISE) begin : g_rise
      logic last;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) last <= RST_VAL;
        else     last <= stage[DEPTH-1];
      end
      assign q = stage[DEPTH-1] & ~last;
    end else begin : g_level
      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/i2s_receive.sv
// I2S receiver: oversamples bit clock, word select and data in clk, frames
// MSB-first left/right words and presents stereo pairs on valid/ready.
//
// state | meaning
// SEEK  | waiting for a genuine 1->0 word-select edge, data ignored
// LEFT  | collecting left word, closes on 0->1 edge
// RIGHT | collecting right word, closes on 1->0 edge and completes the pair
module i2s_receive
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk_in,
  input  logic                lr_clk_in,
  input  logic                serial_in,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                out_valid,
  output logic                overrun
);

  localparam int CNT_W = $clog2(SAMPLE_W + 1);

  logic sr, ws, sd;

  bit_sync #(.DEPTH(2), .RST_VAL(1'b0),     .RISE(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk_in),   .q(sr));
  bit_sync #(.DEPTH(2), .RST_VAL(WS_RIGHT), .RISE(1'b0)) u_sync_ws (
    .clk(clk), .rst(rst), .d(lr_clk_in), .q(ws));
  bit_sync #(.DEPTH(2), .RST_VAL(1'b0),     .RISE(1'b0)) u_sync_sd (
    .clk(clk), .rst(rst), .d(serial_in), .q(sd));

  state_t              state;
  logic                ws_prev;
  logic                primed;
  logic [SAMPLE_W-1:0] shifter, left_hold;
  logic [CNT_W-1:0]    cnt;

  logic                t_edge, pair_done;
  logic [SAMPLE_W-1:0] sh_n, word;
  logic [CNT_W-1:0]    cnt_n;

  always_comb begin
    t_edge = sr && (ws != ws_prev);
    sh_n   = shifter;
    cnt_n  = cnt;
    if (cnt < CNT_W'(SAMPLE_W)) begin
      sh_n  = {shifter[SAMPLE_W-2:0], sd};
      cnt_n = cnt + 1'b1;
    end
    // short words are left-justified, long ones already had their tail dropped
    word      = sh_n << (CNT_W'(SAMPLE_W) - cnt_n);
    pair_done = t_edge && (state == RIGHT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SEEK;
      ws_prev   <= WS_RIGHT;
      primed    <= 1'b0;
      shifter   <= '0;
      cnt       <= '0;
      left_hold <= '0;
      sample_l  <= '0;
      sample_r  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sr) begin
        ws_prev <= ws;
        // the reset value of ws_prev must not pass for a real 1->0 edge
        primed  <= 1'b1;
        case (state)
          SEEK: begin
            if (t_edge && (ws == WS_LEFT) && primed) state <= LEFT;
          end
          LEFT: begin
            if (t_edge) begin
              left_hold <= word;
              shifter   <= '0;
              cnt       <= '0;
              state     <= RIGHT;
            end else begin
              shifter <= sh_n;
              cnt     <= cnt_n;
            end
          end
          RIGHT: begin
            if (t_edge) begin
              shifter <= '0;
              cnt     <= '0;
              state   <= LEFT;
            end else begin
              shifter <= sh_n;
              cnt     <= cnt_n;
            end
          end
          default: state <= SEEK;
        endcase
      end

      overrun <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (pair_done) begin
        if (!out_valid || out_ready) begin
          sample_l  <= left_hold;
          sample_r  <= word;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_receive.sv
// Bench for i2s_receive: table-driven and random frames against a word-level
// reference, plus hand sequences for latency, backpressure and reset cases.
module tb_i2s_receive;

  logic        clk, rst, sclk, lr, sd, out_ready;
  logic [15:0] sample_l, sample_r;
  logic        out_valid, overrun;

  i2s_receive #(.SAMPLE_W(16)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk), .lr_clk_in(lr), .serial_in(sd),
    .out_ready(out_ready), .sample_l(sample_l), .sample_r(sample_r),
    .out_valid(out_valid), .overrun(overrun));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int          n;
    logic [31:0] l;
    logic [31:0] r;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  vec_t        tbl[8];
  int          vectors, miscompares;
  logic [31:0] got[$];
  logic [31:0] expq[$];
  int          ov_pulses, ov_cycles;
  logic        ov_prev, hold_prev;
  logic [31:0] hold_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: keep the top 16 received bits, zero-pad short words
  function automatic logic [15:0] justify(input logic [31:0] v, input int n);
    logic [31:0] t;
    if (n >= 16) t = v >> (n - 16);
    else         t = v << (16 - n);
    return t[15:0];
  endfunction

  // monitor: accepted pairs, overrun pulses, hold stability
  initial begin
    ov_prev = 1'b0;
    hold_prev = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
        hold_prev = 1'b0;
      end else begin
        if (hold_prev && out_valid) check("hold_stable", {sample_l, sample_r}, hold_val);
        hold_prev = out_valid && !out_ready;
        hold_val  = {sample_l, sample_r};
        if (out_valid && out_ready) got.push_back({sample_l, sample_r});
        if (overrun) ov_cycles++;
        if (overrun && !ov_prev) ov_pulses++;
        ov_prev = overrun;
      end
    end
  end

  task automatic send_bit(input logic w, input logic b);
    sclk = 1'b0; lr = w; sd = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // word-select changes one bit early: the LSB already carries the next channel
  task automatic send_word(input logic ch, input logic next_ch, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit((i == 0) ? next_ch : ch, v[i]);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_word(1'b0, 1'b1, l, n);
    send_word(1'b1, 1'b0, r, n);
    expq.push_back({justify(l, n), justify(r, n)});
  endtask

  // like send_frame, but measures clk edges from the final sclk rise to the pair
  task automatic send_frame_timed(input logic [31:0] l, input logic [31:0] r, input int n,
                                  input bit raise_ready, output int lat);
    logic [15:0] el, er;
    el = justify(l, n);
    er = justify(r, n);
    expq.push_back({el, er});
    send_word(1'b0, 1'b1, l, n);
    for (int i = n - 1; i >= 1; i--) send_bit(1'b1, r[i]);
    sclk = 1'b0; lr = 1'b0; sd = r[0];
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    lat = -1;
    @(posedge clk);
    @(posedge clk);
    #2 if (raise_ready) out_ready = 1'b1;
    for (int k = 2; k < 10; k++) begin
      @(negedge clk);
      if (lat < 0 && out_valid && sample_l == el && sample_r == er) lat = k;
    end
  endtask

  task automatic apply_reset(input logic rdy);
    rst = 1'b1; sclk = 1'b0; lr = 1'b1; sd = 1'b0; out_ready = rdy;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    ov_pulses = 0; ov_cycles = 0;
    got.delete(); expq.delete();
  endtask

  task automatic preamble();
    send_word(1'b1, 1'b0, 32'h0, 4);
  endtask

  task automatic idle();
    repeat (12) @(negedge clk);
  endtask

  task automatic check_pairs(input string name);
    check({name, "_count"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++) check(name, got[i], expq[i]);
  endtask

  initial begin
    int lat, n;
    logic [31:0] l, r, mask;
    vectors = 0; miscompares = 0;
    ov_pulses = 0; ov_cycles = 0;
    tbl[0] = '{16, 32'h0000A5C3, 32'h00001234, 16'hA5C3, 16'h1234};
    tbl[1] = '{24, 32'h00ABCDEF, 32'h00123456, 16'hABCD, 16'h1234};
    tbl[2] = '{12, 32'h00000ABC, 32'h00000123, 16'hABC0, 16'h1230};
    tbl[3] = '{16, 32'h00000001, 32'h00008000, 16'h0001, 16'h8000};
    tbl[4] = '{16, 32'h00007FFF, 32'h0000FFFF, 16'h7FFF, 16'hFFFF};
    tbl[5] = '{ 8, 32'h00000080, 32'h0000007F, 16'h8000, 16'h7F00};
    tbl[6] = '{17, 32'h0001FFFF, 32'h00010001, 16'hFFFF, 16'h8000};
    tbl[7] = '{ 1, 32'h00000001, 32'h00000000, 16'h8000, 16'h0000};

    // reset state, then lock: release reset with word select low mid left word
    rst = 1'b1; sclk = 1'b0; lr = 1'b0; sd = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sample_l", 32'(sample_l), 32'd0);
    check("rst_sample_r", 32'(sample_r), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    rst = 1'b0;
    got.delete(); expq.delete();
    send_word(1'b0, 1'b1, 32'h2D, 6);
    send_word(1'b1, 1'b0, 32'h5A5A, 16);
    for (int i = 3; i <= 4; i++) begin
      send_frame(tbl[i].l, tbl[i].r, tbl[i].n);
      expq[expq.size()-1] = {tbl[i].el, tbl[i].er};
    end
    idle();
    check_pairs("lock");

    // table: widths 1..24, constant expectations
    apply_reset(1'b1);
    preamble();
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].l, tbl[i].r, tbl[i].n);
      expq[expq.size()-1] = {tbl[i].el, tbl[i].er};
    end
    idle();
    check_pairs("table");
    check("table_overrun", 32'(ov_pulses), 32'd0);

    // nominal frame with latency
    apply_reset(1'b1);
    preamble();
    send_frame_timed(32'hA5C3, 32'h1234, 16, 1'b0, lat);
    idle();
    check("nominal_latency", 32'(lat), 32'd3);
    check_pairs("nominal");
    check("nominal_overrun", 32'(ov_pulses), 32'd0);

    // random widths and data against the reference
    apply_reset(1'b1);
    preamble();
    for (int i = 0; i < 8; i++) begin
      n = $urandom_range(4, 28);
      mask = (32'h1 << n) - 32'h1;
      l = $urandom & mask;
      r = $urandom & mask;
      send_frame(l, r, n);
    end
    idle();
    check_pairs("random");

    // backpressure: second pair is dropped with one overrun pulse
    apply_reset(1'b0);
    preamble();
    send_frame(32'h1111, 32'h2222, 16);
    idle();
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_overrun_first", 32'(ov_pulses), 32'd0);
    send_frame(32'h3333, 32'h4444, 16);
    void'(expq.pop_back());
    idle();
    check("bp_overrun_pulses", 32'(ov_pulses), 32'd1);
    check("bp_overrun_cycles", 32'(ov_cycles), 32'd1);
    check("bp_held", {sample_l, sample_r}, 32'h11112222);
    @(posedge clk);
    #2 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_clear", 32'(out_valid), 32'd0);
    check_pairs("bp");

    // accept in the very cycle the next pair completes
    apply_reset(1'b0);
    preamble();
    send_frame(32'h5555, 32'h6666, 16);
    idle();
    send_frame_timed(32'h7777, 32'h8888, 16, 1'b1, lat);
    check("simul_latency", 32'(lat), 32'd3);
    idle();
    check("simul_overrun", 32'(ov_pulses), 32'd0);
    check("simul_valid_clear", 32'(out_valid), 32'd0);
    check_pairs("simul");

    // asynchronous reset in the middle of a right word
    apply_reset(1'b0);
    preamble();
    send_frame(32'h9999, 32'hAAAA, 16);
    idle();
    check("mid_held", 32'(out_valid), 32'd1);
    send_word(1'b0, 1'b1, 32'hBBBB, 16);
    for (int i = 15; i >= 11; i--) send_bit(1'b1, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("mid_rst_l", 32'(sample_l), 32'd0);
    check("mid_rst_r", 32'(sample_r), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    got.delete(); expq.delete();
    send_word(1'b1, 1'b0, 32'h0CCC, 11);
    send_frame(32'hD00D, 32'hE00E, 16);
    idle();
    check_pairs("mid_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
